// File: rtl/jpeg_rle_reader.sv
// Drains one 64-coefficient quantized block in zigzag order and emits JPEG
// run/size/amplitude tokens (DC difference, ZRL, AC, EOB) over a valid/ready port.
module jpeg_rle_reader (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        dc_clear_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [4:0]  mem_addr_o,
  input  logic [31:0] mem_dat_i,
  output logic        tok_valid_o,
  input  logic        tok_ready_i,
  output logic [3:0]  tok_run_o,
  output logic [3:0]  tok_size_o,
  output logic [10:0] tok_amp_o,
  output logic        tok_dc_o,
  output logic        tok_eob_o
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] READ = 3'd2;
  localparam logic [2:0] EVAL = 3'd3;
  localparam logic [2:0] ZRL  = 3'd4;
  localparam logic [2:0] EMIT = 3'd5;
  localparam logic [2:0] EOB  = 3'd6;
  localparam logic [2:0] DONE = 3'd7;

  // zigzag position -> raster index (row*8+col)
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [2:0]         state;
  logic [5:0]         idx;
  logic [5:0]         run;
  logic signed [11:0] pred;
  logic signed [11:0] coef;

  logic [5:0]         zz_cur;
  logic signed [15:0] half;
  logic signed [11:0] half_sat;
  logic signed [12:0] diff13;
  logic signed [11:0] val;
  logic [10:0]        mag;
  logic [10:0]        amp_src;
  logic [3:0]         size;
  logic [10:0]        amp;

  assign zz_cur     = ZZ[idx];
  assign mem_addr_o = zz_cur[5:1];
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);

  always_comb begin
    half = zz_cur[0] ? mem_dat_i[15:0] : mem_dat_i[31:16];
    if (half > 16'sd2047)
      half_sat = 12'sd2047;
    else if (half < -16'sd2047)
      half_sat = -12'sd2047;
    else
      half_sat = half[11:0];
  end

  // Value being tokenised: saturated DC difference at i=0, otherwise the coefficient.
  always_comb begin
    diff13 = {coef[11], coef} - {pred[11], pred};
    if (idx != 6'd0)
      val = coef;
    else if (diff13 > 13'sd2047)
      val = 12'sd2047;
    else if (diff13 < -13'sd2047)
      val = -12'sd2047;
    else
      val = diff13[11:0];
  end

  always_comb begin
    mag     = val[11] ? (~val[10:0] + 11'd1) : val[10:0];
    amp_src = val[10:0] - {10'd0, val[11]};
    size    = '0;
    amp     = '0;
    for (int unsigned b = 0; b < 11; b++)
      if (mag[b]) size = 4'(b + 1);
    for (int unsigned b = 0; b < 11; b++)
      amp[b] = (4'(b) < size) ? amp_src[b] : 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      run         <= '0;
      pred        <= '0;
      coef        <= '0;
      tok_valid_o <= 1'b0;
      tok_run_o   <= '0;
      tok_size_o  <= '0;
      tok_amp_o   <= '0;
      tok_dc_o    <= 1'b0;
      tok_eob_o   <= 1'b0;
    end else begin
      // a clear in the same cycle as the DC acceptance wins
      if (dc_clear_i)
        pred <= '0;
      else if (state == EMIT && tok_ready_i && tok_dc_o)
        pred <= coef;

      case (state)
        IDLE: if (start_i) begin
          idx   <= '0;
          run   <= '0;
          state <= ADDR;
        end
        ADDR: state <= READ;
        READ: begin
          coef  <= half_sat;
          state <= EVAL;
        end
        EVAL: begin
          if (idx == 6'd0 || coef != 12'sd0) begin
            tok_valid_o <= 1'b1;
            tok_dc_o    <= (idx == 6'd0);
            tok_eob_o   <= 1'b0;
            if (run > 6'd15) begin
              tok_run_o  <= 4'd15;
              tok_size_o <= '0;
              tok_amp_o  <= '0;
              run        <= run - 6'd16;
              state      <= ZRL;
            end else begin
              tok_run_o  <= run[3:0];
              tok_size_o <= size;
              tok_amp_o  <= amp;
              state      <= EMIT;
            end
          end else begin
            run <= run + 6'd1;
            if (idx == 6'd63) begin
              tok_valid_o <= 1'b1;
              tok_dc_o    <= 1'b0;
              tok_eob_o   <= 1'b1;
              tok_run_o   <= '0;
              tok_size_o  <= '0;
              tok_amp_o   <= '0;
              state       <= EOB;
            end else begin
              idx   <= idx + 6'd1;
              state <= ADDR;
            end
          end
        end
        ZRL: if (tok_ready_i) begin
          if (run > 6'd15) begin
            run <= run - 6'd16;
          end else begin
            tok_run_o  <= run[3:0];
            tok_size_o <= size;
            tok_amp_o  <= amp;
            state      <= EMIT;
          end
        end
        EMIT: if (tok_ready_i) begin
          tok_valid_o <= 1'b0;
          run         <= '0;
          if (idx == 6'd63) begin
            state <= DONE;
          end else begin
            idx   <= idx + 6'd1;
            state <= ADDR;
          end
        end
        EOB: if (tok_ready_i) begin
          tok_valid_o <= 1'b0;
          run         <= '0;
          state       <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_rle_reader.sv
// Directed bench for jpeg_rle_reader: small RAM model, token capture queue,
// hand-computed expected token lists.
module tb_jpeg_rle_reader;

  localparam int LIMIT = 3000;
  localparam int TZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dc_clear = 1'b0;
  logic        busy, done;
  logic [4:0]  mem_addr;
  logic [31:0] mem_dat = '0;
  logic        tok_valid;
  logic        tok_ready = 1'b1;
  logic [3:0]  tok_run, tok_size;
  logic [10:0] tok_amp;
  logic        tok_dc, tok_eob;

  logic [31:0] mem [32];
  logic [20:0] toks [$];
  logic [20:0] exp_q [$];
  int          done_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  jpeg_rle_reader dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dc_clear_i(dc_clear),
    .busy_o(busy), .done_o(done), .mem_addr_o(mem_addr), .mem_dat_i(mem_dat),
    .tok_valid_o(tok_valid), .tok_ready_i(tok_ready), .tok_run_o(tok_run),
    .tok_size_o(tok_size), .tok_amp_o(tok_amp), .tok_dc_o(tok_dc), .tok_eob_o(tok_eob)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_dat <= mem[mem_addr];

  always @(negedge clk) begin
    if (!rst && tok_valid && tok_ready)
      toks.push_back({tok_eob, tok_dc, tok_run, tok_size, tok_amp});
    if (!rst && done)
      done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] tk(input bit eob, input bit dc, input int run,
                                     input int size, input int amp);
    return {eob, dc, 4'(run), 4'(size), 11'(amp)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  task automatic set_zz(input int pos, input int val);
    logic [5:0]  r;
    logic [15:0] h;
    r = 6'(TZZ[pos]);
    h = 16'(val);
    if (r[0]) mem[r[5:1]][15:0] = h;
    else      mem[r[5:1]][31:16] = h;
  endtask

  task automatic run_block(input string tag, input int stall_tok, input bit extra_start,
                           input bit clr);
    int          cyc;
    bit          stalled;
    logic [20:0] snap;
    toks.delete();
    done_cnt = 0;
    stalled  = 0;
    @(posedge clk); #1;
    start = 1'b1; dc_clear = clr;
    @(posedge clk); #1;
    start = 1'b0; dc_clear = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < LIMIT) begin
      if (stall_tok >= 0 && !stalled && tok_valid && toks.size() == stall_tok) begin
        stalled   = 1;
        snap      = {tok_eob, tok_dc, tok_run, tok_size, tok_amp};
        tok_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check({tag, "_hold"}, {10'd0, tok_valid, tok_eob, tok_dc, tok_run, tok_size, tok_amp},
                {10'd0, 1'b1, snap});
          @(posedge clk); #1;
          cyc++;
        end
        tok_ready = 1'b1;
      end
      start = (extra_start && cyc == 20);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_timeout"}, 32'(cyc < LIMIT), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_ntok"}, 32'(toks.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_tok%0d", tag, i),
            (i < toks.size()) ? 32'(toks[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
  endtask

  task automatic exp_zz40();
    exp_q = '{tk(0, 1, 0, 0, 0), tk(0, 0, 15, 0, 0), tk(0, 0, 15, 0, 0),
              tk(0, 0, 7, 1, 1), tk(1, 0, 0, 0, 0)};
  endtask

  task automatic exp_zz63();
    exp_q = '{tk(0, 1, 0, 0, 0), tk(0, 0, 15, 0, 0), tk(0, 0, 15, 0, 0),
              tk(0, 0, 15, 0, 0), tk(0, 0, 14, 1, 0)};
  endtask

  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(tok_valid), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_tok", 32'({tok_eob, tok_dc, tok_run, tok_size, tok_amp}), 32'd0);
    rst = 1'b0;

    exp_q = '{tk(0, 1, 0, 0, 0), tk(1, 0, 0, 0, 0)};
    run_block("zero", -1, 0, 0);

    set_zz(0, 100);
    exp_q = '{tk(0, 1, 0, 7, 100), tk(1, 0, 0, 0, 0)};
    run_block("dc100", -1, 0, 0);

    set_zz(0, 90);
    exp_q = '{tk(0, 1, 0, 4, 5), tk(1, 0, 0, 0, 0)};
    run_block("dc90", -1, 0, 0);

    // pred is 90 here; the coincident clear must make the DC diff 0
    clear_mem();
    set_zz(40, 1);
    exp_zz40();
    run_block("zz40clr", -1, 0, 1);

    clear_mem();
    set_zz(63, -1);
    exp_zz63();
    run_block("zz63", -1, 0, 0);

    clear_mem();
    set_zz(40, 1);
    exp_zz40();
    run_block("stall", 2, 0, 0);

    clear_mem();
    set_zz(63, -1);
    exp_zz63();
    run_block("busystart", -1, 1, 0);
    repeat (5) @(posedge clk);
    #1;
    check("busystart_idle", 32'(busy), 32'd0);
    check("busystart_notok", 32'(toks.size()), 32'(exp_q.size()));

    set_zz(0, 50);
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(tok_valid), 32'd0);
    check("midrst_addr", 32'(mem_addr), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("midrst_nodone", 32'(done_cnt), 32'd0);

    // pred was 50 before reset; reset must zero it
    clear_mem();
    set_zz(0, 100);
    exp_q = '{tk(0, 1, 0, 7, 100), tk(1, 0, 0, 0, 0)};
    run_block("postrst", -1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
